// File: rtl/finder_scan_controller.sv
// Sequences the horizontal then vertical finder scanners over one shared frame-buffer
// read port, latches each pass's encoding vector and reports completion or timeout.
`timescale 1ns/1ps
module finder_scan_controller #(
    parameter int WIDTH   = 480,
    parameter int HEIGHT  = 480,
    parameter int ADDR_W  = 20,
    parameter int TIMEOUT = 1_048_575
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    input  logic [ADDR_W-1:0] h_addr_in,
    input  logic [ADDR_W-1:0] v_addr_in,
    input  logic [WIDTH-1:0]  h_encodings_in,
    input  logic [WIDTH-1:0]  v_encodings_in,
    input  logic              h_valid_in,
    input  logic              v_valid_in,
    output logic [ADDR_W-1:0] bram_addr_out,
    output logic              finder_rst_out,
    output logic              h_start_out,
    output logic              v_start_out,
    output logic [WIDTH-1:0]  row_encodings_out,
    output logic [WIDTH-1:0]  col_encodings_out,
    output logic              busy_out,
    output logic              done_out,
    output logic              timeout_out
);

    localparam int CNT_W = 20;

    if (WIDTH * HEIGHT > (1 << ADDR_W)) begin : g_addr_too_narrow
        $error("frame does not fit in ADDR_W address bits");
    end
    if (TIMEOUT >= (1 << CNT_W)) begin : g_timeout_too_wide
        $error("TIMEOUT does not fit the pass counter");
    end

    typedef enum logic [2:0] {
        IDLE, H_CLEAR, H_START, H_RUN, V_CLEAR, V_START, V_RUN, DONE
    } state_t;

    typedef enum logic [1:0] {
        GRANT_NONE, GRANT_H, GRANT_V
    } grant_t;

    state_t             state, state_next;
    grant_t             grant, grant_next;
    logic [CNT_W-1:0]   pass_cnt;
    logic               h_capture, v_capture, pass_expired;

    assign h_capture    = (state == H_RUN) && h_valid_in;
    assign v_capture    = (state == V_RUN) && v_valid_in;
    assign pass_expired = (pass_cnt == CNT_W'(TIMEOUT))
                          && (((state == H_RUN) && !h_valid_in)
                           || ((state == V_RUN) && !v_valid_in));

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_next     = state;
        grant_next     = GRANT_NONE;
        finder_rst_out = rst_in;
        h_start_out    = 1'b0;
        v_start_out    = 1'b0;
        busy_out       = (state != IDLE);
        done_out       = 1'b0;
        unique case (state)
            IDLE:    if (start_in) state_next = H_CLEAR;
            H_CLEAR: begin
                finder_rst_out = 1'b1;
                state_next     = H_START;
            end
            H_START: begin
                h_start_out = 1'b1;
                state_next  = H_RUN;
            end
            H_RUN: begin
                if (h_capture)         state_next = V_CLEAR;
                else if (pass_expired) state_next = DONE;
            end
            V_CLEAR: begin
                finder_rst_out = 1'b1;
                state_next     = V_START;
            end
            V_START: begin
                v_start_out = 1'b1;
                state_next  = V_RUN;
            end
            V_RUN: begin
                if (v_capture || pass_expired) state_next = DONE;
            end
            DONE: begin
                done_out   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Grant follows the state being entered, so it is registered alongside it.
        if (state_next == H_START || state_next == H_RUN) grant_next = GRANT_H;
        if (state_next == V_START || state_next == V_RUN) grant_next = GRANT_V;
    end

    always_comb begin
        bram_addr_out = '0;
        unique case (grant)
            GRANT_H: bram_addr_out = h_addr_in;
            GRANT_V: bram_addr_out = v_addr_in;
            default: bram_addr_out = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state             <= IDLE;
            grant             <= GRANT_NONE;
            pass_cnt          <= '0;
            row_encodings_out <= '0;
            col_encodings_out <= '0;
            timeout_out       <= 1'b0;
        end else begin
            state <= state_next;
            grant <= grant_next;
            if (state == H_CLEAR || state == V_CLEAR)
                pass_cnt <= '0;
            else if (state == H_START || state == H_RUN || state == V_START || state == V_RUN)
                pass_cnt <= pass_cnt + 1'b1;
            if (h_capture) row_encodings_out <= h_encodings_in;
            if (v_capture) col_encodings_out <= v_encodings_in;
            if (state == IDLE && start_in) timeout_out <= 1'b0;
            else if (pass_expired)         timeout_out <= 1'b1;
        end
    end

endmodule

// File: tb/tb_finder_scan_controller.sv
// Directed bench for finder_scan_controller: nominal pass, address mux, timeout,
// ignored inputs, async reset mid-pass and back-to-back scans.
`timescale 1ns/1ps
module tb_finder_scan_controller;

    localparam int W  = 8;
    localparam int AW = 20;
    localparam int TO = 50;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          start_in;
    logic [AW-1:0] h_addr_in, v_addr_in;
    logic [W-1:0]  h_encodings_in, v_encodings_in;
    logic          h_valid_in, v_valid_in;
    logic [AW-1:0] bram_addr_out;
    logic          finder_rst_out, h_start_out, v_start_out;
    logic [W-1:0]  row_encodings_out, col_encodings_out;
    logic          busy_out, done_out, timeout_out;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int vstart_cnt = 0;

    finder_scan_controller #(
        .WIDTH(W), .HEIGHT(8), .ADDR_W(AW), .TIMEOUT(TO)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
        .h_addr_in(h_addr_in), .v_addr_in(v_addr_in),
        .h_encodings_in(h_encodings_in), .v_encodings_in(v_encodings_in),
        .h_valid_in(h_valid_in), .v_valid_in(v_valid_in),
        .bram_addr_out(bram_addr_out), .finder_rst_out(finder_rst_out),
        .h_start_out(h_start_out), .v_start_out(v_start_out),
        .row_encodings_out(row_encodings_out), .col_encodings_out(col_encodings_out),
        .busy_out(busy_out), .done_out(done_out), .timeout_out(timeout_out)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (done_out)    done_cnt++;
        if (v_start_out) vstart_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    initial begin
        int vs0;
        rst_in = 1'b1;
        start_in = 1'b0;
        h_addr_in = AW'(17);
        v_addr_in = AW'(42);
        h_encodings_in = '0;
        v_encodings_in = '0;
        h_valid_in = 1'b0;
        v_valid_in = 1'b0;
        tick(2);

        // Reset state
        check("rst_frst", finder_rst_out, 1);
        check("rst_busy", busy_out, 0);
        check("rst_done", done_out, 0);
        check("rst_timeout", timeout_out, 0);
        check("rst_row", row_encodings_out, 0);
        check("rst_col", col_encodings_out, 0);
        check("rst_bram", bram_addr_out, 0);
        check("rst_hstart", h_start_out, 0);
        rst_in = 1'b0;
        tick();
        check("idle_frst", finder_rst_out, 0);
        check("idle_bram", bram_addr_out, 0);

        // Nominal pass with address mux and ignored inputs
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        check("hclr_frst", finder_rst_out, 1);
        check("hclr_busy", busy_out, 1);
        check("hclr_bram", bram_addr_out, 0);
        check("hclr_hstart", h_start_out, 0);
        tick();
        check("hst_hstart", h_start_out, 1);
        check("hst_frst", finder_rst_out, 0);
        check("hst_bram", bram_addr_out, 17);
        tick(4);
        start_in = 1'b1;
        v_valid_in = 1'b1;
        v_encodings_in = 8'hFF;
        tick();
        start_in = 1'b0;
        v_valid_in = 1'b0;
        check("ign_hstart", h_start_out, 0);
        check("ign_frst", finder_rst_out, 0);
        check("ign_busy", busy_out, 1);
        check("ign_bram", bram_addr_out, 17);
        check("ign_col", col_encodings_out, 0);
        tick(14);
        h_valid_in = 1'b1;
        h_encodings_in = 8'hA5;
        tick();
        h_valid_in = 1'b0;
        check("hcap_row", row_encodings_out, 8'hA5);
        check("hcap_frst", finder_rst_out, 1);
        check("hcap_vstart", v_start_out, 0);
        check("vclr_bram", bram_addr_out, 0);
        tick();
        check("vst_vstart", v_start_out, 1);
        check("vst_frst", finder_rst_out, 0);
        check("vst_bram", bram_addr_out, 42);
        tick(29);
        check("vrun_bram", bram_addr_out, 42);
        v_valid_in = 1'b1;
        v_encodings_in = 8'h3C;
        tick();
        v_valid_in = 1'b0;
        check("nom_col", col_encodings_out, 8'h3C);
        check("nom_row", row_encodings_out, 8'hA5);
        check("nom_done", done_out, 1);
        check("nom_busy_done", busy_out, 1);
        check("nom_timeout", timeout_out, 0);
        tick();
        check("nom_done_low", done_out, 0);
        check("nom_busy_low", busy_out, 0);
        check("nom_done_cnt", done_cnt, 1);

        // Timeout: no h_valid_in
        vs0 = vstart_cnt;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        tick();
        check("to_hstart", h_start_out, 1);
        tick(TO);
        check("to_pre_done", done_out, 0);
        check("to_pre_busy", busy_out, 1);
        check("to_pre_flag", timeout_out, 0);
        tick();
        check("to_done", done_out, 1);
        check("to_flag", timeout_out, 1);
        check("to_row_kept", row_encodings_out, 8'hA5);
        tick();
        check("to_idle_busy", busy_out, 0);
        check("to_sticky", timeout_out, 1);
        check("to_no_vstart", vstart_cnt, vs0);
        check("to_done_cnt", done_cnt, 2);

        // Back-to-back start in the cycle after done_out; simultaneous valids
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        check("b2b_accept", busy_out, 1);
        check("b2b_to_clear", timeout_out, 0);
        tick();
        check("b2b_hstart", h_start_out, 1);
        tick(3);
        h_valid_in = 1'b1;
        h_encodings_in = 8'h5A;
        v_valid_in = 1'b1;
        v_encodings_in = 8'hC3;
        tick();
        h_valid_in = 1'b0;
        v_valid_in = 1'b0;
        check("both_row", row_encodings_out, 8'h5A);
        check("both_col_kept", col_encodings_out, 8'h3C);
        check("both_frst", finder_rst_out, 1);
        tick();
        check("b2b_vstart", v_start_out, 1);
        tick(2);
        v_valid_in = 1'b1;
        v_encodings_in = 8'h96;
        tick();
        v_valid_in = 1'b0;
        check("b2b_col", col_encodings_out, 8'h96);
        check("b2b_done", done_out, 1);
        tick();
        check("b2b_idle", busy_out, 0);
        check("b2b_done_cnt", done_cnt, 3);

        // Async reset mid V_RUN
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        tick(3);
        h_valid_in = 1'b1;
        h_encodings_in = 8'h11;
        tick();
        h_valid_in = 1'b0;
        tick(4);
        check("mid_vrun_bram", bram_addr_out, 42);
        #3;
        rst_in = 1'b1;
        #1;
        check("arst_busy", busy_out, 0);
        check("arst_frst", finder_rst_out, 1);
        check("arst_row", row_encodings_out, 0);
        check("arst_col", col_encodings_out, 0);
        check("arst_bram", bram_addr_out, 0);
        check("arst_done", done_out, 0);
        tick(2);
        check("arst_no_done", done_cnt, 3);
        rst_in = 1'b0;
        tick();
        check("rel_frst", finder_rst_out, 0);
        check("rel_busy", busy_out, 0);
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        tick(2);
        h_valid_in = 1'b1;
        h_encodings_in = 8'h22;
        tick();
        h_valid_in = 1'b0;
        tick(2);
        v_valid_in = 1'b1;
        v_encodings_in = 8'h33;
        tick();
        v_valid_in = 1'b0;
        check("fresh_row", row_encodings_out, 8'h22);
        check("fresh_col", col_encodings_out, 8'h33);
        check("fresh_done", done_out, 1);
        check("fresh_timeout", timeout_out, 0);
        tick();
        check("fresh_idle", busy_out, 0);
        check("fresh_done_cnt", done_cnt, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
